// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the keyboard clock/data, deserialise 11-bit frames,
// and buffer the scancodes in a small FIFO. Each scancode is handed out with a 1-cycle psint strobe, gated by busy.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       busy,
  output logic [7:0] datao,
  output logic       psint,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt, fall;
  logic [FW-1:0]          fcnt;

  state_t                 state, state_n;
  logic [7:0]             sr, sr_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic                   par, par_n;
  logic [TW-1:0]          tcnt, tcnt_n;
  logic                   push, perr_n, ferr_n;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;
  logic                   full, pop, wr, ovf_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_s;
          fcnt <= '0;
          fall <= filt;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    push      = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    tcnt_n    = (state == IDLE || fall) ? '0 : tcnt + TW'(1);
    case (state)
      IDLE: if (fall && !data_s) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (fall) begin
        sr_n      = {data_s, sr[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        par_n   = data_s;
        state_n = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        if (!data_s)        ferr_n = 1'b1;
        else if (^{sr, par}) push  = 1'b1;
        else                 perr_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A stalled keyboard abandons the partial frame.
    if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end
  end

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop   = (count != '0) && !busy && !psint;
  assign wr    = push && (!full || pop);
  assign ovf_n = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= sr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      datao      <= '0;
      psint      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        datao  <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      psint      <= pop;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overflow   <= ovf_n;
    end
  end

endmodule
